// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell over WIDTH
// cycles, LSB first, with a start/ready/done handshake.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.

// Combinational 1-bit full-adder cell shared by the controller.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter wide enough for 0..WIDTH-1, at least one bit for WIDTH=1.
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_a_q, shift_a_d;
  logic [WIDTH-1:0]   shift_b_q, shift_b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               cell_sum;
  logic               cell_cout;

  // The single shared adder cell always sees the current LSBs and held carry.
  full_adder_cell u_cell (
    .a    (shift_a_q[0]),
    .b    (shift_b_q[0]),
    .cin  (carry_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // State and datapath registers; reset clears everything, ready idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      bitcnt_q  <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      bitcnt_q  <= bitcnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Next-state, datapath sequencing and registered status decode.
  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    bitcnt_d  = bitcnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d     = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          shift_a_d = a_in;
          shift_b_d = b_in;
          carry_d   = cin_in;
          bitcnt_d  = '0;
          res_d     = '0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // New sum bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_d     = (res_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
        carry_d   = cell_cout;
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        bitcnt_d  = bitcnt_q + CNT_W'(1);
        if (bitcnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          sum_d   = res_d;
          cout_d  = cell_cout;
`ifdef SERIAL_ADD_OVF_EN
          // Carry into the MSB is the held carry on the final step.
          ovf_d   = carry_q ^ cell_cout;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d != ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases from the
// handshake/latency rules plus randomized operands against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_cmp;
  int n_err;

  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the sequence is fixed-length, this only guards against a stuck sim.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer addition; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {v, t};
  endfunction

  // Called at a negedge: requests an add, checks the RUN window and the done cycle.
  // glitch>0 pulses start with other operands at that RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int glitch, input string nm);
    logic [W+1:0] e;
    e      = ref_add(a, b, c);
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    cin_in = c;
    @(negedge clk);
    start  = 1'b0;
    a_in   = W'($urandom);
    b_in   = W'($urandom);
    cin_in = 1'($urandom);
    for (int k = 1; k <= int'(W); k++) begin
      chk({nm, "/busy"}, 32'(busy), 32'd1);
      chk({nm, "/ready_run"}, 32'(ready), 32'd0);
      chk({nm, "/done_early"}, 32'(done), 32'd0);
      chk({nm, "/sum_hold"}, 32'(sum_out), 32'(prev_sum));
      chk({nm, "/cout_hold"}, 32'(cout_out), 32'(prev_cout));
      if (k == glitch) begin
        start = 1'b1;
        a_in  = ~a;
        b_in  = a;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "/done"}, 32'(done), 32'd1);
    chk({nm, "/ready_done"}, 32'(ready), 32'd1);
    chk({nm, "/busy_done"}, 32'(busy), 32'd0);
    chk({nm, "/sum"}, 32'(sum_out), 32'(e[W-1:0]));
    chk({nm, "/cout"}, 32'(cout_out), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
    chk({nm, "/ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
    prev_sum  = e[W-1:0];
    prev_cout = e[W];
    prev_ovf  = e[W+1];
  endtask

  // Called at the DONE negedge with no new request: one idle cycle follows.
  task automatic idle_after(input string nm);
    @(negedge clk);
    chk({nm, "/done_pulse"}, 32'(done), 32'd0);
    chk({nm, "/ready_idle"}, 32'(ready), 32'd1);
    chk({nm, "/sum_idle"}, 32'(sum_out), 32'(prev_sum));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    n_cmp     = 0;
    n_err     = 0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cin_in    = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst/ready", 32'(ready), 32'd1);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/sum", 32'(sum_out), 32'd0);
    chk("rst/cout", 32'(cout_out), 32'd0);

    // Basic add, then back-to-back request raised during DONE.
    run_op(8'h5A, 8'h3C, 1'b0, 0, "basic");
    run_op(8'hFF, 8'h01, 1'b0, 0, "b2b");
    idle_after("b2b");

    // Full carry chain; previous 0x00 must hold throughout.
    run_op(8'hFF, 8'hFF, 1'b1, 0, "chain");
    idle_after("chain");

    // Start during RUN is ignored.
    run_op(8'h21, 8'h43, 1'b1, 3, "busy_start");
    idle_after("busy_start");
    @(negedge clk);
    chk("busy_start/no_second_done", 32'(done), 32'd0);

    // Reset in the middle of an operation.
    start  = 1'b1;
    a_in   = 8'hC3;
    b_in   = 8'h5A;
    cin_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst/ready", 32'(ready), 32'd1);
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/done", 32'(done), 32'd0);
    chk("midrst/sum", 32'(sum_out), 32'd0);
    chk("midrst/cout", 32'(cout_out), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("midrst/ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    for (int k = 0; k < int'(W) + 2; k++) begin
      @(negedge clk);
      chk("midrst/no_done", 32'(done), 32'd0);
    end
    run_op(8'h01, 8'h02, 1'b0, 0, "fresh");
    idle_after("fresh");

    // Signed overflow corners (sum/cout checked in every build).
    run_op(8'h7F, 8'h01, 1'b0, 0, "ovf_pos");
    run_op(8'h80, 8'h80, 1'b0, 0, "ovf_neg");
    run_op(8'h10, 8'h20, 1'b0, 0, "ovf_none");
    idle_after("ovf_none");

    // Randomized operands, randomly back-to-back or with an idle gap.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, 0, "rand");
      if ($urandom_range(1, 0) == 0) begin
        idle_after("rand");
        repeat ($urandom_range(2, 0)) @(negedge clk);
      end
    end
    idle_after("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
